mdu_iter: RTL and testbench

- Iterative multiply/divide unit for the multicycle MIPS datapath. Executes MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
- Sits upstream of the ALU-result register. The MFHI/MFLO path selects hi/lo onto the result bus, which is registered one cycle later.
- The control FSM stalls on busy and resumes on done.

---
 rtl/mdu_iter_if.sv | 25 ++
 rtl/mdu_iter.sv | 146 ++++++++++++++
 tb/tb_mdu_iter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - operand, HI/LO access and status bundle for the iterative multiply/divide unit
interface mdu_iter_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; MDU_EARLY_OUT_EN enables multiply early-out
module mdu_iter #(
    parameter int ITER = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_iter_if.slave bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [63:0] r_prod, r_mcand;
    logic [31:0] r_mplr, r_rem, r_quo, r_dvsr, r_hi, r_lo;
    logic [CW-1:0] r_cnt;
    logic        r_is_div, r_neg_q, r_neg_r, r_dbz;

    logic        w_ready, w_accept, w_mt_ok, w_sa, w_sb, w_last, w_mul_last;
    logic [31:0] w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
    logic [32:0] w_trial;
    logic [63:0] w_prod_fix;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = w_ready && bus.start;
    assign w_mt_ok  = w_ready && !bus.start;
    assign w_sa     = bus.op[0] & bus.a[31];
    assign w_sb     = bus.op[0] & bus.b[31];
    assign w_abs_a  = w_sa ? (~bus.a + 32'd1) : bus.a;
    assign w_abs_b  = w_sb ? (~bus.b + 32'd1) : bus.b;
    assign w_last   = (r_cnt == CW'(ITER - 1));

`ifdef MDU_EARLY_OUT_EN
    // Stop once no set multiplier bits remain beyond the one just consumed.
    assign w_mul_last = w_last || (r_mplr[31:1] == 31'd0);
`else
    assign w_mul_last = w_last;
`endif

    // Restoring step: shift the next dividend bit into the partial remainder and try the subtract.
    assign w_trial    = {r_rem, r_quo[31]} - {1'b0, r_dvsr};
    assign w_prod_fix = r_neg_q ? (~r_prod + 64'd1) : r_prod;
    assign w_quo_fix  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_fix  = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start)              w_next = bus.op[1] ? S_DIV : S_MUL;
                else if (r_state == S_DONE) w_next = S_IDLE;
            end
            S_MUL:   if (w_mul_last) w_next = S_FIX;
            S_DIV:   if (w_last)     w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.div_by_zero = 1'b0;
        case (r_state)
            S_MUL, S_DIV, S_FIX: bus.busy = 1'b1;
            S_DONE: begin
                bus.done        = 1'b1;
                bus.div_by_zero = r_dbz;
            end
            default: ;
        endcase
    end

    assign bus.hi = r_hi;
    assign bus.lo = r_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_accept) begin
                r_prod   <= '0;
                r_mcand  <= {32'd0, w_abs_a};
                r_mplr   <= w_abs_b;
                r_rem    <= '0;
                r_quo    <= w_abs_a;
                r_dvsr   <= w_abs_b;
                r_cnt    <= '0;
                r_is_div <= bus.op[1];
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
            end
            if (w_mt_ok && bus.mthi) r_hi <= bus.wdata;
            if (w_mt_ok && bus.mtlo) r_lo <= bus.wdata;

            case (r_state)
                S_MUL: begin
                    if (r_mplr[0]) r_prod <= r_prod + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    if (!w_trial[32]) begin
                        r_rem <= w_trial[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[30:0], r_quo[31]};
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        // A zero divisor leaves the dividend magnitude in r_rem, so hi comes back as a.
                        r_hi  <= w_rem_fix;
                        r_lo  <= (r_dvsr == 32'd0) ? 32'hFFFF_FFFF : w_quo_fix;
                        r_dbz <= (r_dvsr == 32'd0);
                    end else begin
                        r_hi  <= w_prod_fix[63:32];
                        r_lo  <= w_prod_fix[31:0];
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mdu_iter_if bus();

    mdu_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ez = 1'b0;
        if (!op[1]) begin
            if (op[0]) begin
                q = sa * sb;
                p = q;
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else if (!op[0]) begin
            el = a / b;
            eh = a % b;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end
    endtask

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
        int          lat;
        logic [31:0] mb;
        lat = 33;
`ifdef MDU_EARLY_OUT_EN
        if (!op[1]) begin
            mb  = (op[0] && b[31]) ? -b : b;
            lat = 2;
            for (int k = 1; k < 32; k++) if (mb[k]) lat = k + 2;
        end
`else
        mb = b;
        if (op[1] && mb[0]) lat = 33;
`endif
        return lat;
    endfunction

    // mode: 0 plain, 1 mtlo together with start, 2 mtlo pulsed while busy
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [31:0] eh, el, hold_hi, hold_lo;
        logic        ez, held;
        int          lat, nb, xl;
        model(op, a, b, eh, el, ez);
        xl = exp_latency(op, b);
        @(negedge clk);
        hold_hi   = bus.hi;
        hold_lo   = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.mtlo  = (mode == 1);
        bus.wdata = 32'h5A5A_0F0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat  = 0;
        nb   = 0;
        held = 1'b1;
        while (!bus.done && lat < 100) begin
            if (bus.busy) nb++;
            if (bus.hi !== hold_hi || bus.lo !== hold_lo) held = 1'b0;
            if (mode == 2) bus.mtlo = (lat >= 5 && lat < 8);
            @(posedge clk); #1;
            lat++;
        end
        bus.mtlo = 1'b0;
        check("latency", 64'(lat), 64'(xl));
        check("busy_cycles", 64'(nb), 64'(xl));
        check("hilo_hold", {63'd0, held}, 64'd1);
        check("hi", {32'd0, bus.hi}, {32'd0, eh});
        check("lo", {32'd0, bus.lo}, {32'd0, el});
        check("dbz", {63'd0, bus.div_by_zero}, {63'd0, ez});
        @(posedge clk); #1;
        check("done_pulse", {63'd0, bus.done}, 64'd0);
        check("dbz_clear", {63'd0, bus.div_by_zero}, 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        check("mthi", {32'd0, bus.hi}, 64'h0000_0000_AAAA_5555);
        check("mthi_lo_kept", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthi_mtlo", {bus.hi, bus.lo}, 64'h1357_9BDF_1357_9BDF);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'b00, 32'd5, 32'd1, 0);
        run_op(2'b10, 32'd100, 32'd7, 0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b11, 32'h1234_5678, 32'd0, 0);
        run_op(2'b10, 32'h8765_4321, 32'd0, 0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'b10, 32'hDEAD_BEEF, 32'd3, 2);
        run_op(2'b01, 32'h0001_0003, 32'hFFFF_FF00, 1);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                2:       rb = -32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 0);
        end

        // Reset while the multiply is at its tenth step.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'hCAFE_F00D;
        bus.b     = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b11, 32'hFFFF_FF00, 32'd9, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
